// File: rtl/dummy_idx_inserter.sv
// Streams the latched sparse-polynomial indices to poly_mult, interleaving LFSR-chosen dummy beats.
// Dummy insertion is compiled in only when DUMMY_INSERT_EN is defined; otherwise only real beats are sent.
module dummy_idx_inserter #(
  parameter int          IDX_W         = 8,
  parameter int          N_REAL        = 16,
  parameter int          N_DUMMY       = 8,
  parameter logic [15:0] LFSR_SEED_DEF = 16'hACE1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load_i,
  input  logic [N_REAL*IDX_W-1:0] idx_i,
  input  logic [15:0]             seed_i,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic [IDX_W-1:0]        out_idx_o,
  output logic                    out_dummy_o,
  output logic                    out_last_o,
  output logic                    busy_o,
  output logic                    done_o
);

  localparam int CNT_W = $clog2(N_REAL + N_DUMMY + 1);
  localparam int PTR_W = (N_REAL > 1) ? $clog2(N_REAL) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EMIT,
    S_DONE
  } state_t;

  state_t                  r_state;
  logic [N_REAL*IDX_W-1:0] r_idx;
  logic [CNT_W-1:0]        r_rem_real;
  logic [PTR_W-1:0]        r_ptr;
  logic                    r_valid;
  logic                    r_busy;
  logic                    r_done;

  logic                    w_fire;
  logic                    w_is_dummy;
  logic                    w_last;
  logic [IDX_W-1:0]        w_real_idx;
  logic [IDX_W-1:0]        w_dummy_idx;

`ifdef DUMMY_INSERT_EN
  logic [CNT_W-1:0] r_rem_dummy;
  logic [15:0]      r_lfsr;
  logic [15:0]      w_lfsr_next;
  logic [15:0]      w_seed;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_is_dummy = 1'b0;
    if (r_rem_real == '0)       w_is_dummy = 1'b1;
    else if (r_rem_dummy == '0) w_is_dummy = 1'b0;
    else                        w_is_dummy = r_lfsr[0];
  end

  assign w_lfsr_next = {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);
  assign w_seed      = (seed_i == 16'h0000) ? LFSR_SEED_DEF : seed_i;
  assign w_last      = (r_rem_real + r_rem_dummy) == CNT_W'(1);
  assign w_dummy_idx = r_lfsr[IDX_W-1:0];
`else
  logic w_unused_seed;

  assign w_unused_seed = ^seed_i;
  assign w_is_dummy    = 1'b0;
  assign w_last        = r_rem_real == CNT_W'(1);
  assign w_dummy_idx   = '0;
`endif

  assign w_fire     = r_valid & out_ready_i;
  assign w_real_idx = r_idx[r_ptr*IDX_W +: IDX_W];

  // Beat fields come straight from held state, so they stay stable while ready is low.
  assign out_valid_o = r_valid;
  assign out_idx_o   = r_valid ? (w_is_dummy ? w_dummy_idx : w_real_idx) : '0;
  assign out_dummy_o = r_valid & w_is_dummy;
  assign out_last_o  = r_valid & w_last;
  assign busy_o      = r_busy;
  assign done_o      = r_done;

  // NOTE: the key register is pure data qualified by the load; it needs no reset value.
  always_ff @(posedge clk) begin
    if (!rst && r_state == S_IDLE && load_i) begin
      r_idx <= idx_i;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_valid     <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_rem_real  <= '0;
      r_ptr       <= '0;
`ifdef DUMMY_INSERT_EN
      r_rem_dummy <= '0;
      r_lfsr      <= LFSR_SEED_DEF;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (load_i) begin
            r_state     <= S_EMIT;
            r_valid     <= 1'b1;
            r_busy      <= 1'b1;
            r_rem_real  <= CNT_W'(N_REAL);
            r_ptr       <= '0;
`ifdef DUMMY_INSERT_EN
            r_rem_dummy <= CNT_W'(N_DUMMY);
            r_lfsr      <= w_seed;
`endif
          end
        end
        S_EMIT: begin
          if (w_fire) begin
            if (!w_is_dummy) begin
              r_rem_real <= r_rem_real - CNT_W'(1);
              r_ptr      <= r_ptr + PTR_W'(1);
            end
`ifdef DUMMY_INSERT_EN
            else begin
              r_rem_dummy <= r_rem_dummy - CNT_W'(1);
            end
            r_lfsr <= w_lfsr_next;
`endif
            if (w_last) begin
              r_state <= S_DONE;
              r_valid <= 1'b0;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dummy_idx_inserter.sv
// Scoreboard bench for dummy_idx_inserter; expected beats come from a bench-side LFSR model.
// Follows the DUMMY_INSERT_EN setting of the build for the expected beat mix.
module tb_dummy_idx_inserter;

  localparam int IDX_W   = 8;
  localparam int N_REAL  = 16;
  localparam int N_DUMMY = 8;
`ifdef DUMMY_INSERT_EN
  localparam int N_EXP_DUMMY = N_DUMMY;
`else
  localparam int N_EXP_DUMMY = 0;
`endif
  localparam int N_TOTAL = N_REAL + N_EXP_DUMMY;

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic             dummy;
    logic             last;
  } beat_t;

  beat_t sb_q[$];

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    load_i;
  logic [N_REAL*IDX_W-1:0] idx_i;
  logic [15:0]             seed_i;
  logic                    out_valid_o;
  logic                    out_ready_i;
  logic [IDX_W-1:0]        out_idx_o;
  logic                    out_dummy_o;
  logic                    out_last_o;
  logic                    busy_o;
  logic                    done_o;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  dummy_idx_inserter #(
    .IDX_W        (IDX_W),
    .N_REAL       (N_REAL),
    .N_DUMMY      (N_DUMMY),
    .LFSR_SEED_DEF(16'hACE1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .load_i     (load_i),
    .idx_i      (idx_i),
    .seed_i     (seed_i),
    .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i),
    .out_idx_o  (out_idx_o),
    .out_dummy_o(out_dummy_o),
    .out_last_o (out_last_o),
    .busy_o     (busy_o),
    .done_o     (done_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model of one run: pushes every expected beat in order.
  function automatic void build_model(input logic [N_REAL*IDX_W-1:0] idx, input logic [15:0] seed);
    beat_t e;
`ifdef DUMMY_INSERT_EN
    logic [15:0] l;
    int rr;
    int rd;
    int p;
    l  = (seed == 16'h0000) ? 16'hACE1 : seed;
    rr = N_REAL;
    rd = N_DUMMY;
    p  = 0;
    for (int b = 0; b < N_TOTAL; b++) begin
      e.dummy = (rr == 0) ? 1'b1 : (rd == 0) ? 1'b0 : l[0];
      e.idx   = e.dummy ? l[IDX_W-1:0] : idx[p*IDX_W +: IDX_W];
      e.last  = (b == N_TOTAL - 1);
      if (e.dummy) rd--;
      else begin
        rr--;
        p++;
      end
      l = {1'b0, l[15:1]} ^ (l[0] ? 16'hB400 : 16'h0000);
      sb_q.push_back(e);
    end
`else
    for (int b = 0; b < N_REAL; b++) begin
      e.dummy = 1'b0;
      e.idx   = idx[b*IDX_W +: IDX_W];
      e.last  = (b == N_REAL - 1);
      sb_q.push_back(e);
    end
`endif
  endfunction

  task automatic start(input logic [N_REAL*IDX_W-1:0] idx, input logic [15:0] seed);
    @(negedge clk);
    idx_i  = idx;
    seed_i = seed;
    load_i = 1'b1;
    sb_q.delete();
    build_model(idx, seed);
    @(negedge clk);
    load_i = 1'b0;
    check("first_valid_latency", out_valid_o, 1);
    check("busy_after_load", busy_o, 1);
  endtask

  // Drives ready with pct% probability, compares transfers, optionally injects a stray load or a reset.
  task automatic drain(input int pct, input int glitch_at, input int rst_at);
    int    beats   = 0;
    int    dummies = 0;
    int    cyc     = 0;
    bit    held    = 1'b0;
    bit    finished = 1'b0;
    beat_t hb;
    beat_t got;
    beat_t exp_b;
    while (!finished && cyc < 1000) begin
      got = '{out_idx_o, out_dummy_o, out_last_o};
      if (held) check("hold_stable", got, hb);
      if (out_valid_o) check("busy_in_emit", busy_o, 1);
      load_i = 1'b0;
      if (beats == rst_at) begin
        rst         = 1'b1;
        out_ready_i = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        check("rst_valid", out_valid_o, 0);
        check("rst_idx", out_idx_o, 0);
        check("rst_dummy", out_dummy_o, 0);
        check("rst_last", out_last_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_done", done_o, 0);
        sb_q.delete();
        @(negedge clk);
        check("no_done_after_rst", done_o, 0);
        check("idle_after_rst", out_valid_o, 0);
        return;
      end
      if (beats == glitch_at && out_valid_o) begin
        load_i = 1'b1;
        idx_i  = ~idx_i;
        seed_i = seed_i ^ 16'h5A5A;
      end
      out_ready_i = ($urandom_range(99) < pct);
      held        = 1'b0;
      if (out_valid_o) begin
        if (out_ready_i) begin
          if (sb_q.size() == 0) begin
            check("sb_underflow", 1, 0);
          end else begin
            exp_b = sb_q.pop_front();
            check("beat_idx", got.idx, exp_b.idx);
            check("beat_dummy", got.dummy, exp_b.dummy);
            check("beat_last", got.last, exp_b.last);
          end
          beats++;
          dummies += int'(got.dummy);
          if (got.last) finished = 1'b1;
        end else begin
          held = 1'b1;
          hb   = got;
        end
      end
      @(negedge clk);
      load_i = 1'b0;
      cyc++;
    end
    check("run_finished", finished, 1);
    if (pct >= 100) check("no_bubbles", cyc, N_TOTAL);
    check("done_pulse", done_o, 1);
    check("valid_in_done", out_valid_o, 0);
    check("busy_in_done", busy_o, 0);
    @(negedge clk);
    check("done_one_cycle", done_o, 0);
    check("beat_count", beats, N_TOTAL);
    check("dummy_count", dummies, N_EXP_DUMMY);
    check("sb_empty", sb_q.size(), 0);
  endtask

  logic [N_REAL*IDX_W-1:0] ramp;
  logic [N_REAL*IDX_W-1:0] rnd;

  initial begin
    rst         = 1'b1;
    load_i      = 1'b0;
    out_ready_i = 1'b0;
    idx_i       = '0;
    seed_i      = '0;
    for (int k = 0; k < N_REAL; k++) ramp[k*IDX_W +: IDX_W] = IDX_W'(k);
    for (int k = 0; k < N_REAL; k++) rnd[k*IDX_W +: IDX_W] = IDX_W'($urandom_range(255));
    rnd[3*IDX_W +: IDX_W] = rnd[2*IDX_W +: IDX_W];

    repeat (3) @(negedge clk);
    check("reset_valid", out_valid_o, 0);
    check("reset_busy", busy_o, 0);
    check("reset_done", done_o, 0);
    check("reset_last", out_last_o, 0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_valid", out_valid_o, 0);

    start(ramp, 16'h0001);
    drain(100, -1, -1);

    start(rnd, 16'h0000);
    drain(100, -1, -1);

    for (int r = 0; r < 3; r++) begin
      start(rnd ^ {N_REAL{IDX_W'(r * 37)}}, 16'($urandom_range(1, 65535)));
      drain(50, -1, -1);
    end

    start(ramp, 16'h1234);
    drain(100, 5, -1);

    start(rnd, 16'hBEEF);
    drain(100, -1, 10);
    start(ramp, 16'h0001);
    drain(100, -1, -1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
